// File: rtl/fp_mul_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fp_mul_arbiter_pkg
//  Shared constants and types for the fp_mul_arbiter block.
//  Holds the floating-point word width, the default requester count and the
//  default multiplier latency. It also defines the tag-pipe entry type and a
//  small round-robin helper.
//  No ports (package).
// ---------------------------------------------------------------------------
package fp_mul_arbiter_pkg;

   // IEEE-754 single-precision word width
   localparam int FP_W = 32;

   // Default configuration of the arbiter
   localparam int DEF_NREQ    = 4;
   localparam int DEF_MUL_LAT = 1;
   localparam int DEF_CNT_W   = 16;

   // Requester indices are carried in a fixed 3-bit field, enough for the
   // largest supported requester count of 8
   localparam int MAX_NREQ = 8;
   localparam int IDX_W    = 3;

   typedef logic [FP_W-1:0] fpWord_t;

   // One slot of the owner-tracking shift register
   typedef struct packed {
      logic             valid;
      logic [IDX_W-1:0] idx;
   } tagEntry_t;

   // Index that follows 'idx' in round-robin order among 'n' requesters
   function automatic int rrNext(input int idx, input int n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/fp_mul_arbiter_if.sv
// ---------------------------------------------------------------------------
// fp_mul_arbiter_if
//  Requester-side bus of the shared multiplier arbiter.
//  It carries the operand handshake from the feature-extraction units and the
//  product routed back to them.
//  Signals:
//   req_valid  NREQ       requester i has an operand pair
//   req_a      NREQ*32    operand A, requester i at [32*i +: 32]
//   req_b      NREQ*32    operand B, same packing
//   req_ready  NREQ       one-hot grant (combinational)
//   rsp_valid  NREQ       one-hot, single-cycle product owner
//   rsp_data   32         registered product
//  Modports:
//   master  requester side (drives operands, receives grants and products)
//   slave   arbiter side
// ---------------------------------------------------------------------------
interface fp_mul_arbiter_if
   import fp_mul_arbiter_pkg::*;
#(
   parameter int NREQ = DEF_NREQ
);

   logic [NREQ-1:0]      req_valid;
   logic [NREQ*FP_W-1:0] req_a;
   logic [NREQ*FP_W-1:0] req_b;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ-1:0]      rsp_valid;
   fpWord_t              rsp_data;

   modport master (
      output req_valid,
      output req_a,
      output req_b,
      input  req_ready,
      input  rsp_valid,
      input  rsp_data
   );

   modport slave (
      input  req_valid,
      input  req_a,
      input  req_b,
      output req_ready,
      output rsp_valid,
      output rsp_data
   );

endinterface

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//  Purely combinational round-robin arbiter.
//  The search starts at 'ptr' and runs upward, wrapping modulo NREQ. It is
//  built as a mask + priority-encode double search: requests at or above ptr
//  are searched first, and only if none exist is the full request vector
//  searched from bit 0.
//  Ports:
//   req  in   NREQ    request vector
//   ptr  in   PTR_W   index with the highest priority this cycle
//   en   in   1       0 forces an empty grant
//   gnt  out  NREQ    one-hot grant (all zero when nothing wins)
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ  = 4,
   parameter int PTR_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0]  req,
   input  logic [PTR_W-1:0] ptr,
   input  logic             en,
   output logic [NREQ-1:0] gnt
);

   logic [NREQ-1:0] maskedReq;
   logic [NREQ-1:0] gntHi;
   logic [NREQ-1:0] gntLo;
   logic            foundHi;
   logic            foundLo;

   // The upper search only sees requests at index >= ptr, which gives the
   // wrap-around order ptr, ptr+1, ... NREQ-1. If that search is empty, the
   // plain lowest-index search over all requests covers 0 .. ptr-1. Both
   // encoders pick the lowest set bit of their own vector.
   always_comb begin
      maskedReq = '0;
      gntHi     = '0;
      gntLo     = '0;
      foundHi   = 1'b0;
      foundLo   = 1'b0;

      for (int i = 0; i < NREQ; i++) begin
         maskedReq[i] = req[i] && (i >= int'(ptr));
      end

      for (int i = 0; i < NREQ; i++) begin
         if (maskedReq[i] && !foundHi) begin
            gntHi[i] = 1'b1;
            foundHi  = 1'b1;
         end
         if (req[i] && !foundLo) begin
            gntLo[i] = 1'b1;
            foundLo  = 1'b1;
         end
      end

      if (!en) begin
         gnt = '0;
      end else if (foundHi) begin
         gnt = gntHi;
      end else begin
         gnt = gntLo;
      end
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// ---------------------------------------------------------------------------
// fp_mul_arbiter
//  Shares one single-precision fp_multiplier between NREQ requesters.
//  Each cycle at most one operand pair is granted round-robin and registered
//  onto the multiplier inputs. A tag shift register follows every op through
//  the multiplier, so the product can be steered back to its owner as a
//  one-cycle pulse. The multiplier itself lives in the parent.
//  Ports:
//   clk        in   1       system clock, all logic on posedge
//   rst        in   1       synchronous, active-high reset
//   en         in   1       1 = grants allowed; 0 = no new grants, drain
//   bus        slave        requester handshake and product return
//   mul_a      out  32      registered operand to multiplier in1
//   mul_b      out  32      registered operand to multiplier in2
//   mul_p      in   32      multiplier product (MUL_LAT edges after sample)
//   busy       out  1       some op is in the tag pipe or response stage
//   ops_count  out  CNT_W   accepted ops since reset, wrapping
// ---------------------------------------------------------------------------
module fp_mul_arbiter
   import fp_mul_arbiter_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int MUL_LAT = DEF_MUL_LAT,
   parameter int CNT_W   = DEF_CNT_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   fp_mul_arbiter_if.slave     bus,
   output fpWord_t             mul_a,
   output fpWord_t             mul_b,
   input  fpWord_t             mul_p,
   output logic                busy,
   output logic [CNT_W-1:0]    ops_count
);

   localparam int PTR_W = $clog2(NREQ);

   logic [PTR_W-1:0] ptr_q;
   logic [PTR_W-1:0] ptr_d;
   fpWord_t          mulA_q;
   fpWord_t          mulA_d;
   fpWord_t          mulB_q;
   fpWord_t          mulB_d;
   tagEntry_t        tag_q [MUL_LAT+1];
   tagEntry_t        tag_d;
   logic [NREQ-1:0]  rspValid_q;
   logic [NREQ-1:0]  rspValid_d;
   fpWord_t          rspData_q;
   fpWord_t          rspData_d;
   logic [CNT_W-1:0] opsCount_q;
   logic [CNT_W-1:0] opsCount_d;

   logic [NREQ-1:0]  grant;
   logic             accept;
   logic [IDX_W-1:0] winIdx;
   fpWord_t          selA;
   fpWord_t          selB;
   int               nextIdx;
   tagEntry_t        lastTag;
   logic             busyAny;

   // Grants are held off while reset is asserted so that nothing is accepted
   // on a reset edge. The grant is returned straight to the requesters, and
   // because it is a subset of req_valid, any grant bit is an acceptance.
   rr_arbiter #(
      .NREQ  (NREQ),
      .PTR_W (PTR_W)
   ) u_rrArbiter (
      .req (bus.req_valid),
      .ptr (ptr_q),
      .en  (en && !rst),
      .gnt (grant)
   );

   assign bus.req_ready = grant;

   // Turn the one-hot grant into the winner's index and pick its operands
   // with constant slices. The grant is one-hot, so at most one loop pass
   // writes the outputs.
   always_comb begin
      accept = |grant;
      winIdx = '0;
      selA   = '0;
      selB   = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            winIdx = IDX_W'(i);
            selA   = bus.req_a[FP_W*i +: FP_W];
            selB   = bus.req_b[FP_W*i +: FP_W];
         end
      end
   end

   // The next-state logic for the issue side. The pointer moves just past the
   // winner so that winner has the lowest priority in the next contest. The
   // operand registers hold when nothing is accepted. Any product the
   // multiplier computes from those held operands has no valid tag, so it is
   // never returned.
   always_comb begin
      nextIdx    = rrNext(int'(winIdx), NREQ);
      ptr_d      = ptr_q;
      mulA_d     = mulA_q;
      mulB_d     = mulB_q;
      opsCount_d = opsCount_q;
      if (accept) begin
         ptr_d      = PTR_W'(nextIdx);
         mulA_d     = selA;
         mulB_d     = selB;
         opsCount_d = opsCount_q + CNT_W'(1);
      end
      tag_d.valid = accept;
      tag_d.idx   = winIdx;
   end

   // The next-state logic for the return side. The last tag stage lines up
   // with the cycle in which mul_p belongs to that op. The product is
   // captured untouched and the owner is decoded to a one-hot pulse. When the
   // last stage is empty, the pulse drops and the data holds.
   always_comb begin
      lastTag    = tag_q[MUL_LAT];
      rspValid_d = '0;
      rspData_d  = rspData_q;
      if (lastTag.valid) begin
         rspData_d = mul_p;
         for (int i = 0; i < NREQ; i++) begin
            rspValid_d[i] = (lastTag.idx == IDX_W'(i));
         end
      end
   end

   // The issue registers: pointer, multiplier operands and the op counter.
   // A reset edge returns them to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         mulA_q     <= '0;
         mulB_q     <= '0;
         opsCount_q <= '0;
      end else begin
         ptr_q      <= ptr_d;
         mulA_q     <= mulA_d;
         mulB_q     <= mulB_d;
         opsCount_q <= opsCount_d;
      end
   end

   // The tag shift register has MUL_LAT+1 stages and follows each op through
   // the operand register and the multiplier. Clearing every valid bit on
   // reset discards the ops in flight, so none of them ever produces a
   // response.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k <= MUL_LAT; k++) begin
            tag_q[k] <= '0;
         end
      end else begin
         tag_q[0] <= tag_d;
         for (int k = 1; k <= MUL_LAT; k++) begin
            tag_q[k] <= tag_q[k-1];
         end
      end
   end

   // The response stage: the registered product and the one-hot owner pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         rspValid_q <= '0;
         rspData_q  <= '0;
      end else begin
         rspValid_q <= rspValid_d;
         rspData_q  <= rspData_d;
      end
   end

   // busy covers an op from the moment it is accepted until its response
   // pulse has been presented.
   always_comb begin
      busyAny = |rspValid_q;
      for (int k = 0; k <= MUL_LAT; k++) begin
         busyAny = busyAny | tag_q[k].valid;
      end
   end

   assign mul_a         = mulA_q;
   assign mul_b         = mulB_q;
   assign bus.rsp_valid = rspValid_q;
   assign bus.rsp_data  = rspData_q;
   assign busy          = busyAny;
   assign ops_count     = opsCount_q;

endmodule
